// File: rtl/seg7_count_sequencer.sv
// Hex count sequencer for the 7-segment decoder: debounced run/clear buttons,
// prescaled up/down stepping, parallel load and a manual display override.

module seg7_btn_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          lvl, lvl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      lvl   <= 1'b0;
      lvl_q <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      lvl_q <= lvl;
      if (sync[1] != lvl) begin
        // the level flips on the DEBOUNCE-th consecutive differing sample
        if (cnt == CW'(DEBOUNCE - 1)) begin
          lvl <= sync[1];
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = lvl & ~lvl_q;
endmodule

module seg7_count_sequencer #(
  parameter int PRESCALE = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_run,
  input  logic       btn_clr,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       manual,
  input  logic [3:0] manual_val,
  output logic [3:0] digit,
  output logic [3:0] count,
  output logic       running,
  output logic       step,
  output logic       wrap
);
  localparam int PW = $clog2(PRESCALE);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] pre, pre_nx;
  logic [3:0]    count_nx;
  logic          step_nx, wrap_nx;
  logic [1:0]    btn_raw, press;

  assign btn_raw = {btn_clr, btn_run};

  seg7_btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb [1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_raw),
    .press (press)
  );

  always_comb begin
    state_nx = state;
    count_nx = count;
    pre_nx   = pre;
    step_nx  = 1'b0;
    wrap_nx  = 1'b0;
    if (press[1]) begin
      state_nx = IDLE;
      count_nx = 4'd0;
      pre_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) count_nx = load_val;
          if (press[0]) begin
            state_nx = RUN;
            pre_nx   = '0;
          end
        end
        RUN: begin
          if (pre == PW'(PRESCALE - 1)) begin
            pre_nx   = '0;
            step_nx  = 1'b1;
            wrap_nx  = dir ? (count == 4'd0) : (count == 4'hf);
            count_nx = dir ? count - 4'd1 : count + 4'd1;
          end else begin
            pre_nx = pre + PW'(1);
          end
          if (press[0]) state_nx = PAUSE;
        end
        PAUSE: begin
          // prescaler is left untouched so a resume finishes the open period
          if (load) count_nx = load_val;
          if (press[0]) state_nx = RUN;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pre     <= '0;
      count   <= 4'd0;
      digit   <= 4'd0;
      running <= 1'b0;
      step    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_nx;
      pre     <= pre_nx;
      count   <= count_nx;
      digit   <= manual ? manual_val : count_nx;
      running <= (state_nx == RUN);
      step    <= step_nx;
      wrap    <= wrap_nx;
    end
  end
endmodule

// File: doc/seg7_count_sequencer.md
Name: seg7_count_sequencer

Overview:
- Synchronous controller that sequences the 4-bit hex count feeding the 7-segment decoder.
- Replaces the rippled, button-clocked counter chain with a single-clock design: debounced run/pause and clear buttons, a prescaler and up/down stepping.
- Parallel load, and a manual-override source select for the decoder input.
- Sits between the pad inputs and the existing 7-segment decode logic.

Parameters:
PRESCALE, 4, clk cycles per count step while running (legal: >= 2)
DEBOUNCE, 3, consecutive stable synchronized samples required before a button level is accepted (legal: >= 1)

Ports:
clk  input  1  single system clock
rst_n  input  1  reset, asynchronous assert, active-low
btn_run  input  1  raw asynchronous button; each debounced press toggles run/pause
btn_clr  input  1  raw asynchronous button; debounced press clears the count and returns to IDLE
dir  input  1  0 = count up, 1 = count down; sampled at each step
load  input  1  synchronous level; loads load_val when not running
load_val  input  4  parallel load value
manual  input  1  1 = decoder shows manual_val instead of count
manual_val  input  4  manual display value
digit  output  4  registered value driven to the 7-segment decoder
count  output  4  current counter value
running  output  1  high in RUN
step  output  1  one-cycle pulse; high in the first cycle a new stepped count is visible
wrap  output  1  one-cycle pulse with step when up 15->0 or down 0->15

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. count, digit, prescaler, debounce counters and debounced levels all 0. Synchronizers are 0. running, step and wrap are 0.
- Button path, per button:
  - 2-flop synchronizer.
  - Debounce counter increments while the synchronized level differs from the debounced level. It clears when they match.
  - On reaching DEBOUNCE, the debounced level takes the new value.
  - Press pulse is 1 cycle, high in the first cycle the debounced level reads 1.
  - Latency: a raw rise held stable gives press high on edge 2+DEBOUNCE after the first sampling edge.
  - A glitch shorter than DEBOUNCE samples produces no press.
- States and transitions:
  - IDLE --run press--> RUN (prescaler starts at 0).
  - RUN --run press--> PAUSE (prescaler value held).
  - PAUSE --run press--> RUN (prescaler resumes from held value).
  - Any state --clr press--> IDLE, with count 0 and prescaler 0.
- Prescaler, RUN only:
  - Counts 0..PRESCALE-1.
  - At the edge where it equals PRESCALE-1: it returns to 0, count steps per dir (mod 16), and step is asserted for the following cycle.
  - wrap is asserted together with step on a 15->0 (up) or 0->15 (down) transition.
- Load:
  - In IDLE or PAUSE with load high, count <= load_val on each edge.
  - In RUN, load is ignored.
  - Load produces no step or wrap.
- digit: registered as manual ? manual_val : count_next. One cycle latency from a manual or manual_val change. A count change and digit agree in the same cycle.
- running = (state == RUN), registered.
- Simultaneous events:
  - clr press beats run press and load.
  - run press in PAUSE together with load: load applies and the block enters RUN on the same edge.
  - Terminal prescaler count coinciding with a run press in RUN: the step occurs, then PAUSE.
  - A dir change takes effect at the next step only.
- Reset mid-operation aborts everything immediately. Operation resumes from IDLE after rst_n rises.

Test Plan:
- Reset: assert rst_n low mid-run -> count=0, digit=0, running=0, step=0 within the same cycle. After release, still IDLE.
- Debounce: btn_run high for 2 cycles -> no press, stays IDLE. High for 6 cycles -> running=1 exactly 5 edges after the first sampling edge.
- Count up: RUN, dir=0, load_val preload 14 -> step every 4 cycles. Sequence 15, 0 (wrap=1 with the step to 0), 1. Step pulses are exactly 1 cycle.
- Count down and pause: dir=1 from 1 -> 0, 15 (wrap=1). Run press mid-period -> count frozen. Second press -> next step after the remaining prescaler cycles, not a full 4.
- Load rules: PAUSE, load=1, load_val=9 -> count=9 next cycle, step=0. In RUN, load=1 with load_val=3 -> count unaffected.
- Priority and override: clr and run presses on the same cycle -> IDLE, count=0. Then manual=1, manual_val=A -> digit=A one cycle later, count unchanged.
